// File: rtl/calc_pkg.sv
// Shared constants and helpers for the calculator datapath.
// No ports; imported by the register-file modules.
package calc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NREG   = 4;

  // One-hot load enables for a register index, all zero when not enabled.
  function automatic logic [NREG-1:0] sel_decode(input logic [SEL_W-1:0] sel,
                                                 input logic             en);
    logic [NREG-1:0] onehot;
    onehot      = '0;
    onehot[sel] = en;
    return onehot;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// Single data word: register with asynchronous active-low clear and load enable.
// Ports:
//   ck  - clock, rising edge
//   res - asynchronous active-low clear
//   en  - load enable; d is captured on the rising edge when high
//   d   - load data
//   q   - stored value
module regfile_word
  import calc_pkg::*;
(
  input  logic              ck,
  input  logic              res,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_val;

  // Clear wins over a load presented on the same edge.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_val <= '0;
    end else if (en) begin
      r_val <= d;
    end
  end

  assign q = r_val;

endmodule

// File: rtl/regfile.sv
// Four-entry 16-bit register file: one synchronous write port, one
// combinational read port, and a continuous view of every register.
// Ports:
//   ck            - clock, rising edge
//   res           - asynchronous active-low reset, clears all registers
//   d             - write data
//   wsel, we      - write select and active-high write enable
//   rsel          - read select
//   q             - combinational read data, register[rsel]
//   r_out0..3     - combinational view of each register
module regfile
  import calc_pkg::*;
(
  input  logic              ck,
  input  logic              res,
  output logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] d,
  input  logic [SEL_W-1:0]  rsel,
  input  logic [SEL_W-1:0]  wsel,
  input  logic              we,
  output logic [DATA_W-1:0] r_out0,
  output logic [DATA_W-1:0] r_out1,
  output logic [DATA_W-1:0] r_out2,
  output logic [DATA_W-1:0] r_out3
);

  logic [NREG-1:0]   w_en;
  logic [DATA_W-1:0] w_words [NREG];

  // Write-port decode into per-word load enables.
  assign w_en = sel_decode(wsel, we);

  for (genvar i = 0; i < int'(NREG); i++) begin : g_word
    regfile_word u_word (
      .ck  (ck),
      .res (res),
      .en  (w_en[i]),
      .d   (d),
      .q   (w_words[i])
    );
  end

  // Read mux; no bypass, so a same-cycle write shows only after the edge.
  always_comb begin
    q = '0;
    case (rsel)
      2'd0:    q = w_words[0];
      2'd1:    q = w_words[1];
      2'd2:    q = w_words[2];
      default: q = w_words[3];
    endcase
  end

  assign r_out0 = w_words[0];
  assign r_out1 = w_words[1];
  assign r_out2 = w_words[2];
  assign r_out3 = w_words[3];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: table-driven write vectors with a
// scoreboard of expected register snapshots, plus hand-written sequences
// for reset, read-during-write and reset-versus-write.
module tb_regfile;

  logic        ck;
  logic        res;
  logic [15:0] q;
  logic [15:0] d;
  logic [1:0]  rsel;
  logic [1:0]  wsel;
  logic        we;
  logic [15:0] r_out0, r_out1, r_out2, r_out3;

  int n_total;
  int n_pass;

  typedef struct {
    logic        we;
    logic [1:0]  wsel;
    logic [15:0] d;
  } vec_t;

  vec_t              vecs [12];
  logic [15:0]       mdl  [4];
  logic [3:0][15:0]  sb_q [$];

  regfile dut (
    .ck     (ck),
    .res    (res),
    .q      (q),
    .d      (d),
    .rsel   (rsel),
    .wsel   (wsel),
    .we     (we),
    .r_out0 (r_out0),
    .r_out1 (r_out1),
    .r_out2 (r_out2),
    .r_out3 (r_out3)
  );

  initial ck = 1'b0;
  always #10 ck = ~ck;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Compare all debug outputs and sweep the read port against a snapshot.
  task automatic check_all(input string tag, input logic [3:0][15:0] exp);
    check({tag, " r_out0"}, r_out0, exp[0]);
    check({tag, " r_out1"}, r_out1, exp[1]);
    check({tag, " r_out2"}, r_out2, exp[2]);
    check({tag, " r_out3"}, r_out3, exp[3]);
    for (int i = 0; i < 4; i++) begin
      rsel = 2'(i);
      #1;
      check($sformatf("%s q[rsel=%0d]", tag, i), q, exp[i]);
    end
  endtask

  function automatic logic [3:0][15:0] snap();
    logic [3:0][15:0] s;
    for (int i = 0; i < 4; i++) s[i] = mdl[i];
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mdl[i] = 16'h0000;
  endtask

  task automatic write_now(input logic w, input logic [1:0] ws, input logic [15:0] dv);
    @(negedge ck);
    we = w; wsel = ws; d = dv;
    if (w && res) mdl[ws] = dv;
    @(posedge ck);
    #1;
    we = 1'b0;
  endtask

  initial begin
    logic [3:0][15:0] exp_s;
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{1'b1, 2'd0, 16'd11};
    vecs[1]  = '{1'b1, 2'd1, 16'd22};
    vecs[2]  = '{1'b1, 2'd2, 16'd33};
    vecs[3]  = '{1'b1, 2'd3, 16'd44};
    vecs[4]  = '{1'b0, 2'd2, 16'hFFFF};
    vecs[5]  = '{1'b0, 2'd2, 16'hFFFF};
    vecs[6]  = '{1'b0, 2'd2, 16'hFFFF};
    vecs[7]  = '{1'b1, 2'd3, 16'hFFFF};
    vecs[8]  = '{1'b1, 2'd3, 16'h0000};
    vecs[9]  = '{1'b1, 2'd2, 16'h1234};
    vecs[10] = '{1'b1, 2'd2, 16'hABCD};
    vecs[11] = '{1'b1, 2'd3, 16'd44};

    res = 1'b0; we = 1'b0; wsel = 2'd0; rsel = 2'd0; d = 16'h0000;
    clear_model();

    // Reset state.
    #3;
    check_all("reset", snap());

    // Preload nonzero, then reset with no clock edge.
    @(negedge ck);
    res = 1'b1;
    write_now(1'b1, 2'd0, 16'h0005);
    write_now(1'b1, 2'd1, 16'h0006);
    write_now(1'b1, 2'd2, 16'h0007);
    write_now(1'b1, 2'd3, 16'h0008);
    check_all("preload", snap());
    #2;
    res = 1'b0;
    clear_model();
    #1;
    check_all("async_reset", snap());
    @(negedge ck);
    res = 1'b1;

    // Table-driven writes with scoreboard.
    for (int v = 0; v < 12; v++) begin
      @(negedge ck);
      we = vecs[v].we; wsel = vecs[v].wsel; d = vecs[v].d;
      if (vecs[v].we) mdl[vecs[v].wsel] = vecs[v].d;
      sb_q.push_back(snap());
      @(posedge ck);
      #1;
      we = 1'b0;
      if (sb_q.size() == 0) begin
        check($sformatf("vec%0d scoreboard", v), 16'h0001, 16'h0000);
      end else begin
        exp_s = sb_q.pop_front();
        check_all($sformatf("vec%0d", v), exp_s);
      end
    end

    // Read-during-write: old value before the edge, new after.
    @(negedge ck);
    rsel = 2'd1; wsel = 2'd1; we = 1'b1; d = 16'd500;
    #1;
    check("rdw before edge q", q, 16'd22);
    @(posedge ck);
    #1;
    we = 1'b0;
    mdl[1] = 16'd500;
    check("rdw after edge q", q, 16'd500);
    check_all("rdw", snap());

    // Reset asserted across a write edge wins.
    @(negedge ck);
    res = 1'b0; we = 1'b1; wsel = 2'd0; d = 16'd7;
    clear_model();
    #1;
    check("rst_vs_wr before edge r_out0", r_out0, 16'd0);
    @(posedge ck);
    #1;
    check_all("rst_vs_wr", snap());
    @(negedge ck);
    res = 1'b1;
    mdl[0] = 16'd7;
    @(posedge ck);
    #1;
    we = 1'b0;
    check_all("post_reset_write", snap());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Four-entry, 16-bit general-purpose register file for the calculator datapath.
- One synchronous write port and one combinational read port.
- All four registers are also exported continuously for display and debug.
- Sits between the ALU result bus (d) and the operand bus (q).

Parameters:
- DATA_W, 16, width of each register and of d, q and r_out0..r_out3.
- NREG, 4, number of registers. Fixed at 4; the select width is 2 and there are four r_outN ports.

Ports:
- ck  input  1  system clock; all state updates on the rising edge
- res  input  1  asynchronous, active-low reset; clears all registers
- q  output  16  read data, the contents of register[rsel]
- d  input  16  write data
- rsel  input  2  read select, 0..3
- wsel  input  2  write select, 0..3
- we  input  1  write enable, active-high
- r_out0  output  16  contents of register 0
- r_out1  output  16  contents of register 1
- r_out2  output  16  contents of register 2
- r_out3  output  16  contents of register 3

Behaviour:
- Reset:
  - When res goes low, all four registers clear to 16'h0000 immediately, independent of ck.
  - While res is low, registers hold 0 and writes are ignored.
  - q and r_out0..r_out3 read 0 during reset.
- Reset release: deassertion (res going high) takes effect asynchronously. The first write can occur on the first rising ck edge with res high.
- Write:
  - On the rising ck edge with res high and we=1, register[wsel] <= d.
  - The other three registers hold their values.
  - With we=0, all registers hold.
- Read:
  - q = register[rsel], purely combinational, with no latency from rsel.
  - q changes in the same cycle that rsel changes.
- Debug outputs: r_outN is always a direct, combinational view of register N.
- Read-during-write (rsel == wsel, we=1): q shows the old value until the clock edge and the new value after it. There is no write-through bypass.
- Repeated writes: consecutive-cycle writes to the same register are allowed; the last write wins.
- Unknown selects: X or Z on rsel or wsel is not handled. Behaviour is don't-care; no protection is required.
- Arithmetic: none. Data passes through unmodified at full 16-bit width, with no sign handling.
- Reset mid-operation: an asserted res overrides a write presented on the same edge. The register reads 0, not d.

Decomposition:
- Shared package (calc_pkg), constants:
  - DATA_W=16
  - SEL_W=2
  - NREG=4
- Sub-module regfile_word, instantiated four times:
  - One 16-bit register with async active-low clear and a load enable.
  - Ports: ck, res, en, d, q.
  - Top level provides the wsel/we decode into per-word enables.
  - Top level provides the rsel 4:1 read mux.

Test Plan:
1. Reset: drive res=0 with registers preloaded nonzero, no clock edge -> r_out0..r_out3=0 and q=0 immediately.
2. Write/read each: with we=1, write 16'd11, 22, 33, 44 to wsel=0..3 on successive edges -> r_out0..r_out3 = 11/22/33/44; sweeping rsel=0..3 gives q = 11/22/33/44 combinationally.
3. Write disable: we=0, wsel=2, d=16'hFFFF over 3 edges -> r_out2 stays 33; all other registers unchanged.
4. Read-during-write: rsel=wsel=1, we=1, d=16'd500 -> q=22 before the edge and 500 after it; r_out1=500.
5. Full-range data: write 16'hFFFF then 16'h0000 to reg 3 -> r_out3 reads 65535, then 0, with no truncation.
6. Reset vs write: res=0 asserted with we=1, d=16'd7, wsel=0 across a clock edge -> r_out0 stays 0; after res=1, the next edge with we=1 loads 7.
